// File: rtl/ahb_interconnect_rr.sv
// Multi-master bus interconnect with round-robin arbitration, pipelined address/data
// phases, slave decode with read-data/ready/response return mux and an error default slave.
module ahb_interconnect_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 2,
    parameter int BURST_MAX   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*2-1:0]      m_trans,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_grant,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_ready,
    output logic [1:0]                    m_resp,
    output logic [NUM_SLAVES-1:0]         s_sel,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [1:0]                    s_trans,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]         s_ready,
    input  logic [NUM_SLAVES*2-1:0]       s_resp
);

    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BW = ($clog2(BURST_MAX) > 0) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_MAX - 1);
    localparam logic [SEL_W:0]   SLV_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        D_IDLE,
        D_ERR1,
        D_ERR2
    } dflt_state_t;

    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] next_grant;
    logic [OW-1:0]          owner;
    logic [BW-1:0]          beat_q;
    logic [OW-1:0]          d_owner;
    logic                   d_valid;
    logic [SEL_W-1:0]       d_slave;
    logic [SEL_W-1:0]       slv_idx;
    logic                   addr_active;
    logic                   mapped;
    logic                   unmapped_req;
    logic                   others_req;
    logic                   keep_owner;
    dflt_state_t            dflt_state;
    logic                   dflt_ready;
    logic                   dflt_err;

    assign m_grant = grant_q;

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner = OW'(i);
        end
    end

    // Address phase: one-hot AND-OR mux keyed by the grant
    always_comb begin
        s_addr  = '0;
        s_trans = '0;
        s_write = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_addr  = m_addr[i*ADDR_W +: ADDR_W];
                s_trans = m_trans[i*2 +: 2];
                s_write = m_write[i];
            end
        end
    end

    assign slv_idx      = s_addr[ADDR_W-1 -: SEL_W];
    assign addr_active  = s_trans[1];
    assign mapped       = ({1'b0, slv_idx} < SLV_LIMIT);
    assign unmapped_req = addr_active && !mapped;

    always_comb begin
        s_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (addr_active && slv_idx == SEL_W'(i)) s_sel[i] = 1'b1;
        end
    end

    always_comb begin
        s_wdata = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (d_owner == OW'(i)) s_wdata = m_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Default slave takes precedence while its error sequence is running
    always_comb begin
        m_rdata = '0;
        m_ready = 1'b1;
        m_resp  = 2'b00;
        if (dflt_state != D_IDLE) begin
            m_ready = dflt_ready;
            m_resp  = {1'b0, dflt_err};
        end else if (d_valid) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (d_slave == SEL_W'(i)) begin
                    m_rdata = s_rdata[i*DATA_W +: DATA_W];
                    m_ready = s_ready[i];
                    m_resp  = s_resp[i*2 +: 2];
                end
            end
        end
    end

    assign others_req = |(m_req & ~grant_q);
    assign keep_owner = m_req[owner] && (!others_req || beat_q < BEAT_LAST);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand       = 0;
        found      = 1'b0;
        next_grant = grant_q;
        if (!keep_owner && |m_req) begin
            for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                cand = 32'(owner) + k;
                if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
                if (!found && m_req[cand]) begin
                    next_grant       = '0;
                    next_grant[cand] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= NUM_MASTERS'(1);
            beat_q  <= '0;
            d_owner <= '0;
            d_valid <= 1'b0;
            d_slave <= '0;
        end else if (m_ready) begin
            grant_q <= next_grant;
            if (next_grant != grant_q)
                beat_q <= '0;
            else if (addr_active && beat_q < BEAT_LAST)
                beat_q <= beat_q + 1'b1;
            d_owner <= owner;
            d_valid <= addr_active && mapped;
            d_slave <= slv_idx;
        end
    end

    // Two-cycle error response; keeps running while the bus is stalled in D_ERR1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dflt_state <= D_IDLE;
            dflt_ready <= 1'b1;
            dflt_err   <= 1'b0;
        end else begin
            case (dflt_state)
                D_IDLE: begin
                    if (m_ready && unmapped_req) begin
                        dflt_state <= D_ERR1;
                        dflt_ready <= 1'b0;
                        dflt_err   <= 1'b1;
                    end
                end
                D_ERR1: begin
                    dflt_state <= D_ERR2;
                    dflt_ready <= 1'b1;
                    dflt_err   <= 1'b1;
                end
                D_ERR2: begin
                    if (unmapped_req) begin
                        dflt_state <= D_ERR1;
                        dflt_ready <= 1'b0;
                        dflt_err   <= 1'b1;
                    end else begin
                        dflt_state <= D_IDLE;
                        dflt_ready <= 1'b1;
                        dflt_err   <= 1'b0;
                    end
                end
                default: begin
                    dflt_state <= D_IDLE;
                    dflt_ready <= 1'b1;
                    dflt_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_interconnect_rr.sv
// Self-checking bench for ahb_interconnect_rr: directed scenarios with a data-phase scoreboard.
module tb_ahb_interconnect_rr;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_req;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*2-1:0]   m_trans;
    logic [NM-1:0]     m_write;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_grant;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;
    logic [1:0]        m_resp;
    logic [NS-1:0]     s_sel;
    logic [AW-1:0]     s_addr;
    logic [1:0]        s_trans;
    logic              s_write;
    logic [DW-1:0]     s_wdata;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;
    logic [NS*2-1:0]   s_resp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ready;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } dp_t;

    dp_t         dp_q[$];
    logic [31:0] wd_q[$];

    ahb_interconnect_rr #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SEL_W      (2),
        .BURST_MAX  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_addr (m_addr),
        .m_trans(m_trans),
        .m_write(m_write),
        .m_wdata(m_wdata),
        .m_grant(m_grant),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_resp (m_resp),
        .s_sel  (s_sel),
        .s_addr (s_addr),
        .s_trans(s_trans),
        .s_write(s_write),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .s_ready(s_ready),
        .s_resp (s_resp)
    );

    always #5 clk = ~clk;

    function automatic dp_t mk_dp(input logic r, input logic [1:0] rs, input logic [31:0] d);
        dp_t e;
        e.ready = r;
        e.resp  = rs;
        e.rdata = d;
        return e;
    endfunction

    task automatic set_master(input int i, input logic [15:0] a, input logic [1:0] t,
                              input logic w, input logic [31:0] d);
        m_addr[i*AW +: AW]  = a;
        m_trans[i*2 +: 2]   = t;
        m_write[i]          = w;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        m_req   = '0;
        m_addr  = '0;
        m_trans = '0;
        m_write = '0;
        m_wdata = '0;
        s_ready = '1;
        s_resp  = '0;
        s_rdata = {32'h2222_BBBB, 32'hDEAD_BEEF, 32'h0000_0A0A};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        dp_q.delete();
        wd_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        n_checks++;
        if (m_grant !== 2'b01) begin n_fail++; $display("FAIL reset_grant: got %b want 01", m_grant); end
        n_checks++;
        if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", m_ready); end
        n_checks++;
        if (m_resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", m_resp); end
        n_checks++;
        if (s_sel !== 3'b000) begin n_fail++; $display("FAIL reset_sel: got %b want 000", s_sel); end
        n_checks++;
        if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_read();
        dp_t e;
        do_reset();
        m_req[0] = 1'b1;
        set_master(0, 16'h4010, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (s_sel !== 3'b010) begin n_fail++; $display("FAIL read_sel: got %b want 010", s_sel); end
        n_checks++;
        if (s_addr !== 16'h4010) begin n_fail++; $display("FAIL read_addr: got %h want 4010", s_addr); end
        dp_q.push_back(mk_dp(1'b1, 2'b00, 32'hDEAD_BEEF));
        @(posedge clk);
        #1;
        set_master(0, 16'h4010, 2'b00, 1'b0, 32'h0);
        dp_q.push_back(mk_dp(1'b1, 2'b00, 32'h0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = dp_q.pop_front();
            n_checks++;
            if (m_rdata !== e.rdata || m_resp !== e.resp || m_ready !== e.ready) begin
                n_fail++;
                $display("FAIL read_dphase[%0d]: got rdata=%h resp=%b ready=%b want rdata=%h resp=%b ready=%b",
                         k, m_rdata, m_resp, m_ready, e.rdata, e.resp, e.ready);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_arbitration();
        logic [1:0]  exp_g;
        logic [15:0] exp_a;
        logic [31:0] exp_w;
        do_reset();
        m_req = 2'b11;
        set_master(0, 16'h0004, 2'b11, 1'b1, 32'h1111_1111);
        set_master(1, 16'h4008, 2'b10, 1'b1, 32'h2222_2222);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_g = (((c / 4) % 2) == 1) ? 2'b10 : 2'b01;
            exp_a = (exp_g == 2'b01) ? 16'h0004 : 16'h4008;
            n_checks++;
            if (m_grant !== exp_g || s_addr !== exp_a) begin
                n_fail++;
                $display("FAIL arb_grant[%0d]: got grant=%b addr=%h want grant=%b addr=%h",
                         c, m_grant, s_addr, exp_g, exp_a);
            end
            if (c > 0) begin
                exp_w = wd_q.pop_front();
                n_checks++;
                if (s_wdata !== exp_w) begin
                    n_fail++;
                    $display("FAIL arb_wdata[%0d]: got %h want %h", c, s_wdata, exp_w);
                end
            end
            wd_q.push_back((exp_g == 2'b01) ? 32'h1111_1111 : 32'h2222_2222);
            @(posedge clk);
            #1;
        end
        wd_q.delete();
        // Lone requester beyond the burst limit, then saturated counter hands over at once
        m_req = 2'b10;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (m_grant !== 2'b10) begin n_fail++; $display("FAIL arb_lone[%0d]: got %b want 10", c, m_grant); end
        end
        m_req = 2'b11;
        @(posedge clk);
        #1;
        n_checks++;
        if (m_grant !== 2'b01) begin n_fail++; $display("FAIL arb_saturate: got %b want 01", m_grant); end
        m_req = 2'b10;
        @(posedge clk);
        #1;
        m_req = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (m_grant !== 2'b10) begin n_fail++; $display("FAIL arb_park[%0d]: got %b want 10", c, m_grant); end
        end
    endtask

    task automatic test_default_slave();
        dp_t e;
        do_reset();
        m_req[0] = 1'b1;
        set_master(0, 16'hC000, 2'b10, 1'b1, 32'hCAFE_0001);
        @(negedge clk);
        n_checks++;
        if (s_sel !== 3'b000) begin n_fail++; $display("FAIL dflt_sel: got %b want 000", s_sel); end
        dp_q.push_back(mk_dp(1'b0, 2'b01, 32'h0));
        dp_q.push_back(mk_dp(1'b1, 2'b01, 32'h0));
        dp_q.push_back(mk_dp(1'b1, 2'b00, 32'h0));
        @(posedge clk);
        #1;
        set_master(0, 16'hC000, 2'b00, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = dp_q.pop_front();
            n_checks++;
            if (m_ready !== e.ready || m_resp !== e.resp || m_rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL dflt_seq[%0d]: got ready=%b resp=%b rdata=%h want ready=%b resp=%b rdata=%h",
                         k, m_ready, m_resp, m_rdata, e.ready, e.resp, e.rdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] tr [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic       er [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] es [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        dp_t e;
        do_reset();
        m_req[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_master(0, 16'hC004, tr[k], 1'b0, 32'h0);
            dp_q.push_back(mk_dp(er[k], es[k], 32'h0));
            @(posedge clk);
            @(negedge clk);
            e = dp_q.pop_front();
            n_checks++;
            if (m_ready !== e.ready || m_resp !== e.resp) begin
                n_fail++;
                $display("FAIL b2b_err[%0d]: got ready=%b resp=%b want ready=%b resp=%b",
                         k, m_ready, m_resp, e.ready, e.resp);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        m_req = 2'b01;
        set_master(0, 16'h8004, 2'b10, 1'b1, 32'h5555_AAAA);
        set_master(1, 16'h0008, 2'b10, 1'b1, 32'h6666_0000);
        @(negedge clk);
        n_checks++;
        if (s_sel !== 3'b100) begin n_fail++; $display("FAIL stall_sel: got %b want 100", s_sel); end
        @(posedge clk);
        #1;
        m_req      = 2'b10;
        set_master(0, 16'h8004, 2'b00, 1'b1, 32'h5555_AAAA);
        s_ready[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (m_ready !== 1'b0 || m_grant !== 2'b01 || s_addr !== 16'h8004 || s_wdata !== 32'h5555_AAAA) begin
                n_fail++;
                $display("FAIL stall_freeze[%0d]: got ready=%b grant=%b addr=%h wdata=%h want 0 01 8004 5555aaaa",
                         k, m_ready, m_grant, s_addr, s_wdata);
            end
            @(posedge clk);
            #1;
        end
        s_ready[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b1 || m_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: got ready=%b grant=%b want 1 01", m_ready, m_grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_grant !== 2'b10 || s_addr !== 16'h0008 || s_sel !== 3'b001) begin
            n_fail++;
            $display("FAIL stall_switch: got grant=%b addr=%h sel=%b want 10 0008 001", m_grant, s_addr, s_sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req = 2'b10;
        set_master(1, 16'hC000, 2'b10, 1'b1, 32'h0BAD_0BAD);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b0 || m_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ready=%b grant=%b want 0 10", m_ready, m_grant);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (m_ready !== 1'b1 || m_resp !== 2'b00 || m_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_post: got ready=%b resp=%b grant=%b want 1 00 01", m_ready, m_resp, m_grant);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_read();
        test_arbitration();
        test_default_slave();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
